// File: rtl/cbc_enc_ctrl.sv
`timescale 1ns/1ps
// Purpose : CBC-mode encryption sequencer around a shared AES-128 core (start/done handshake).
// Latency : pt accept at edge N -> aes_start in cycle N+1 -> ct_valid the cycle after aes_done (min 2 cycles).
// Backpr. : one block in flight; ct_valid/ct_data held until ct_ready, pt_ready low until ct accepted.
//
// Ports:
//   clk, rst_n                 - clock, async active-low reset
//   cfg_valid/ready/key/iv     - key + IV load, accepted only in IDLE
//   pt_valid/ready/data/last   - plaintext stream, accepted only in WAIT_PT
//   ct_valid/ready/data/last   - ciphertext stream, held stable until accepted
//   aes_start/in/key/done/out  - external AES core interface
//   abort                      - synchronous return to IDLE, highest priority
//   msg_done                   - one-cycle pulse after the last ciphertext handshake
//   err                        - sticky core timeout flag, cleared by the next config
//   blk_cnt                    - ciphertext blocks delivered in current message (saturating)
module cbc_enc_ctrl #(
  parameter int BLK_W   = 128,
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [BLK_W-1:0] cfg_key,
  input  logic [BLK_W-1:0] cfg_iv,
  input  logic             pt_valid,
  output logic             pt_ready,
  input  logic [BLK_W-1:0] pt_data,
  input  logic             pt_last,
  output logic             ct_valid,
  input  logic             ct_ready,
  output logic [BLK_W-1:0] ct_data,
  output logic             ct_last,
  output logic             aes_start,
  output logic [BLK_W-1:0] aes_in,
  output logic [BLK_W-1:0] aes_key,
  input  logic             aes_done,
  input  logic [BLK_W-1:0] aes_out,
  input  logic             abort,
  output logic             msg_done,
  output logic             err,
  output logic [CNT_W-1:0] blk_cnt
);

  localparam int TMR_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_PT = 2'd1,
    ENC     = 2'd2,
    OUT     = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [BLK_W-1:0] key_reg;
  logic [BLK_W-1:0] chain_reg;
  logic             last_reg;
  logic [TMR_W-1:0] timer;

  logic cfg_hs;
  logic pt_hs;
  logic ct_hs;
  logic tmo_hit;

  assign cfg_hs  = cfg_valid & cfg_ready;
  assign pt_hs   = pt_valid & pt_ready;
  assign ct_hs   = ct_valid & ct_ready;
  // Timeout only fires when the core has not answered in this same cycle.
  assign tmo_hit = (state == ENC) && !aes_done && (timer == TMR_MAX);
  assign aes_key = key_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cfg_ready = 1'b0;
    pt_ready  = 1'b0;
    case (state)
      IDLE: begin
        cfg_ready = 1'b1;
        if (cfg_hs) state_nxt = WAIT_PT;
      end
      WAIT_PT: begin
        pt_ready = 1'b1;
        if (pt_hs) state_nxt = ENC;
      end
      ENC: begin
        if (aes_done)     state_nxt = OUT;
        else if (tmo_hit) state_nxt = IDLE;
      end
      OUT: begin
        if (ct_hs) state_nxt = ct_last ? IDLE : WAIT_PT;
      end
      default: state_nxt = IDLE;
    endcase
    // Abort overrides every other transition; any handshake seen this cycle is dropped.
    if (abort) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_reg   <= '0;
      chain_reg <= '0;
      last_reg  <= 1'b0;
      timer     <= '0;
      aes_in    <= '0;
      aes_start <= 1'b0;
      ct_data   <= '0;
      ct_last   <= 1'b0;
      ct_valid  <= 1'b0;
      blk_cnt   <= '0;
      err       <= 1'b0;
      msg_done  <= 1'b0;
    end else begin
      // Pulses default low every cycle.
      aes_start <= 1'b0;
      msg_done  <= 1'b0;
      if (abort) begin
        // Key, chain, count and err are kept; only the in-flight block is dropped.
        ct_valid <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (cfg_hs) begin
              key_reg   <= cfg_key;
              chain_reg <= cfg_iv;
              blk_cnt   <= '0;
              err       <= 1'b0;
            end
          end
          WAIT_PT: begin
            if (pt_hs) begin
              aes_in    <= pt_data ^ chain_reg;
              last_reg  <= pt_last;
              aes_start <= 1'b1;
              timer     <= '0;
            end
          end
          ENC: begin
            if (aes_done) begin
              ct_data   <= aes_out;
              chain_reg <= aes_out;
              ct_last   <= last_reg;
              ct_valid  <= 1'b1;
            end else if (tmo_hit) begin
              err <= 1'b1;
            end else begin
              timer <= timer + TMR_W'(1);
            end
          end
          OUT: begin
            if (ct_hs) begin
              ct_valid <= 1'b0;
              if (blk_cnt != '1) blk_cnt <= blk_cnt + CNT_W'(1);
              if (ct_last) msg_done <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cbc_enc_ctrl.sv
`timescale 1ns/1ps
module tb_cbc_enc_ctrl;

  localparam int BLK_W   = 128;
  localparam int CNT_W   = 16;
  localparam int TIMEOUT = 64;

  localparam logic [127:0] K0  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] IV0 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P1  = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] A1  = 128'h6bc0bce12a459991e134741a7f9e1925;
  localparam logic [127:0] C1  = 128'h7649abac8119b246cee98e9b12e9197d;
  localparam logic [127:0] P2  = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
  localparam logic [127:0] C2  = 128'h5086cb9b507219ee95db113a917678b2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             cfg_valid, cfg_ready;
  logic [BLK_W-1:0] cfg_key, cfg_iv;
  logic             pt_valid, pt_ready, pt_last;
  logic [BLK_W-1:0] pt_data;
  logic             ct_valid, ct_ready, ct_last;
  logic [BLK_W-1:0] ct_data;
  logic             aes_start;
  logic [BLK_W-1:0] aes_in, aes_key;
  logic             aes_done = 1'b0;
  logic [BLK_W-1:0] aes_out  = '0;
  logic             abort;
  logic             msg_done, err;
  logic [CNT_W-1:0] blk_cnt;

  always #5 clk = ~clk;

  cbc_enc_ctrl #(.BLK_W(BLK_W), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_key(cfg_key), .cfg_iv(cfg_iv),
    .pt_valid(pt_valid), .pt_ready(pt_ready), .pt_data(pt_data), .pt_last(pt_last),
    .ct_valid(ct_valid), .ct_ready(ct_ready), .ct_data(ct_data), .ct_last(ct_last),
    .aes_start(aes_start), .aes_in(aes_in), .aes_key(aes_key),
    .aes_done(aes_done), .aes_out(aes_out),
    .abort(abort), .msg_done(msg_done), .err(err), .blk_cnt(blk_cnt)
  );

  int checks = 0;
  int errors = 0;

  // Stand-in cipher: the two published test vectors, else a keyed word swap.
  function automatic logic [127:0] ref_cipher(input logic [127:0] k, input logic [127:0] x);
    if (k == K0 && x == A1) return C1;
    if (k == K0 && x == (P2 ^ C1)) return C2;
    return {x[63:0], x[127:64]} ^ k ^ 128'h5a5a_1234_a5a5_9876_0f0f_c3c3_3c3c_f00d;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Core model: answers core_lat negedges after aes_start; core_mute silences it.
  int core_lat  = 0;
  bit core_mute = 1'b0;
  int late_req  = 0;
  int late_ack  = 0;
  bit pending   = 1'b0;
  int lat_cnt   = 0;

  always @(negedge clk) begin
    aes_done = 1'b0;
    if (aes_start && !core_mute) begin
      pending = 1'b1;
      lat_cnt = core_lat;
    end
    if (core_mute) pending = 1'b0;
    if (late_req != late_ack) begin
      late_ack = late_req;
      aes_done = 1'b1;
      aes_out  = rnd128();
    end else if (pending) begin
      if (lat_cnt == 0) begin
        aes_done = 1'b1;
        aes_out  = ref_cipher(aes_key, aes_in);
        pending  = 1'b0;
      end else begin
        lat_cnt--;
      end
    end
  end

  // Reference CBC state.
  logic [127:0] m_key, m_chain;
  int           m_cnt;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_cfg(input logic [127:0] k, input logic [127:0] iv);
    int n;
    cfg_key = k; cfg_iv = iv; cfg_valid = 1'b1;
    n = 0;
    while (!cfg_ready && n < 100) begin step(); n++; end
    chk("cfg_ready_wait", 128'(cfg_ready), 128'(1));
    step();
    cfg_valid = 1'b0;
    m_key = k; m_chain = iv; m_cnt = 0;
    chk("cfg_aes_key", aes_key, k);
    chk("cfg_err_clr", 128'(err), 128'(0));
    chk("cfg_blk_cnt", 128'(blk_cnt), 128'(0));
    chk("cfg_pt_ready", 128'(pt_ready), 128'(1));
  endtask

  task automatic send_block(input logic [127:0] pt, input logic last, input int hold,
                            output logic [127:0] got_in, output logic [127:0] got_ct);
    logic [127:0] exp_in, exp_ct;
    int n;
    exp_in = pt ^ m_chain;
    exp_ct = ref_cipher(m_key, exp_in);
    pt_data = pt; pt_last = last; pt_valid = 1'b1;
    n = 0;
    while (!pt_ready && n < 100) begin step(); n++; end
    chk("pt_ready_wait", 128'(pt_ready), 128'(1));
    step();
    pt_valid = 1'b0;
    chk("aes_start", 128'(aes_start), 128'(1));
    chk("aes_in", aes_in, exp_in);
    chk("enc_pt_ready", 128'(pt_ready), 128'(0));
    got_in = aes_in;
    n = 0;
    while (!ct_valid && n < TIMEOUT + 10) begin step(); n++; end
    chk("ct_latency", 128'(n), 128'(core_lat + 1));
    for (int i = 0; i < hold; i++) begin
      chk("bp_ct_valid", 128'(ct_valid), 128'(1));
      chk("bp_ct_data", ct_data, exp_ct);
      chk("bp_pt_ready", 128'(pt_ready), 128'(0));
      chk("bp_aes_start", 128'(aes_start), 128'(0));
      step();
    end
    chk("ct_data", ct_data, exp_ct);
    chk("ct_last", 128'(ct_last), 128'(last));
    got_ct = ct_data;
    ct_ready = 1'b1;
    step();
    ct_ready = 1'b0;
    m_chain = exp_ct;
    if (m_cnt < 65535) m_cnt++;
    chk("ct_valid_drop", 128'(ct_valid), 128'(0));
    chk("blk_cnt", 128'(blk_cnt), 128'(m_cnt));
    chk("msg_done", 128'(msg_done), 128'(last));
    chk("post_cfg_ready", 128'(cfg_ready), 128'(last));
    chk("post_pt_ready", 128'(pt_ready), 128'(!last));
    if (last) begin
      step();
      chk("msg_done_pulse", 128'(msg_done), 128'(0));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] gi, gc;
    int len, n;
    bit seen;
    rst_n = 1'b0; cfg_valid = 1'b0; cfg_key = '0; cfg_iv = '0;
    pt_valid = 1'b0; pt_data = '0; pt_last = 1'b0; ct_ready = 1'b0; abort = 1'b0;

    // Reset values
    repeat (3) step();
    chk("rst_aes_start", 128'(aes_start), 128'(0));
    chk("rst_ct_valid", 128'(ct_valid), 128'(0));
    chk("rst_blk_cnt", 128'(blk_cnt), 128'(0));
    chk("rst_err", 128'(err), 128'(0));
    chk("rst_aes_key", aes_key, 128'(0));
    chk("rst_aes_in", aes_in, 128'(0));
    chk("rst_ct_data", ct_data, 128'(0));
    chk("rst_msg_done", 128'(msg_done), 128'(0));
    chk("rst_pt_ready", 128'(pt_ready), 128'(0));
    rst_n = 1'b1;
    step();
    chk("rel_cfg_ready", 128'(cfg_ready), 128'(1));

    // Plaintext offered in IDLE is ignored
    pt_valid = 1'b1; pt_data = rnd128();
    repeat (3) step();
    chk("idle_pt_ignored", 128'(aes_start), 128'(0));
    chk("idle_pt_ready", 128'(pt_ready), 128'(0));
    pt_valid = 1'b0;

    // SP800-38A CBC vectors, first block under 10 cycles of backpressure
    core_lat = 0;
    do_cfg(K0, IV0);
    cfg_valid = 1'b1; cfg_key = ~K0;
    step();
    chk("busy_cfg_ready", 128'(cfg_ready), 128'(0));
    chk("busy_cfg_ignored", aes_key, K0);
    cfg_valid = 1'b0;
    send_block(P1, 1'b0, 10, gi, gc);
    chk("vec1_aes_in", gi, A1);
    chk("vec1_ct", gc, C1);
    send_block(P2, 1'b1, 0, gi, gc);
    chk("vec2_ct", gc, C2);
    chk("vec2_blk_cnt", 128'(blk_cnt), 128'(2));
    chk("vec2_idle", 128'(cfg_ready), 128'(1));

    // Random messages
    for (int m = 0; m < 6; m++) begin
      core_lat = $urandom_range(0, 4);
      do_cfg(rnd128(), rnd128());
      len = $urandom_range(1, 5);
      for (int b = 0; b < len; b++)
        send_block(rnd128(), (b == len - 1), $urandom_range(0, 3), gi, gc);
    end

    // Timeout with a silent core
    core_lat = 0;
    do_cfg(rnd128(), rnd128());
    core_mute = 1'b1;
    pt_data = rnd128(); pt_last = 1'b1; pt_valid = 1'b1;
    step();
    pt_valid = 1'b0;
    chk("tmo_aes_start", 128'(aes_start), 128'(1));
    for (int i = 1; i <= TIMEOUT; i++) begin
      step();
      if (i == TIMEOUT - 1) chk("tmo_err_early", 128'(err), 128'(0));
    end
    chk("tmo_err", 128'(err), 128'(1));
    chk("tmo_cfg_ready", 128'(cfg_ready), 128'(1));
    chk("tmo_ct_valid", 128'(ct_valid), 128'(0));
    core_mute = 1'b0;
    do_cfg(rnd128(), rnd128());

    // Abort in ENC, then a late aes_done
    send_block(rnd128(), 1'b0, 0, gi, gc);
    core_mute = 1'b1;
    pt_data = rnd128(); pt_last = 1'b0; pt_valid = 1'b1;
    step();
    pt_valid = 1'b0;
    chk("abort_in_enc", 128'(aes_start), 128'(1));
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_idle", 128'(cfg_ready), 128'(1));
    chk("abort_ct_valid", 128'(ct_valid), 128'(0));
    repeat (2) step();
    late_req++;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (ct_valid) seen = 1'b1;
    end
    chk("late_done_ignored", 128'(seen), 128'(0));
    chk("abort_blk_cnt", 128'(blk_cnt), 128'(1));
    chk("abort_still_idle", 128'(cfg_ready), 128'(1));
    core_mute = 1'b0;

    // Async reset while holding a ciphertext in OUT
    core_lat = 1;
    do_cfg(rnd128(), rnd128());
    send_block(rnd128(), 1'b0, 0, gi, gc);
    pt_data = rnd128(); pt_last = 1'b0; pt_valid = 1'b1;
    step();
    pt_valid = 1'b0;
    n = 0;
    while (!ct_valid && n < 20) begin step(); n++; end
    chk("out_reached", 128'(ct_valid), 128'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ct_valid", 128'(ct_valid), 128'(0));
    chk("arst_aes_start", 128'(aes_start), 128'(0));
    chk("arst_blk_cnt", 128'(blk_cnt), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("arst_cfg_ready", 128'(cfg_ready), 128'(1));
    chk("arst_pt_ready", 128'(pt_ready), 128'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
